// File: rtl/lsu_rmw_if.sv
// Load/store request and response bundle between the core and lsu_rmw.
// Handshake: a request transfers on a rising edge where req_valid && req_ready; the
// response is a single-cycle rsp_valid pulse with no back-pressure, and
// rsp_rdata/rsp_err are meaningful only while rsp_valid is high.
interface lsu_rmw_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );
endinterface

// File: rtl/lsu_rmw.sv
// RV32I load/store unit over a private word memory; byte and halfword stores
// are done as read-modify-write of the containing word.
module lsu_rmw #(
  parameter int DEPTH_LOG2 = 6
) (
  input  logic       clk,
  input  logic       reset,
  lsu_rmw_if.slave   bus,
  output logic [1:0] o_dbg_state
);
  localparam int AW = DEPTH_LOG2 + 2;

  typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2, RESP = 2'd3} state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  r_we;
  logic [2:0]            r_f3;
  logic [AW-1:0]         r_addr;
  logic [31:0]           r_wdata;
  logic                  r_err;
  logic [31:0]           r_rdata;
  logic [31:0]           r_mem [0:(1<<DEPTH_LOG2)-1];

  logic                  w_accept;
  logic                  w_f3_ok;
  logic                  w_misalign;
  logic                  w_range;
  logic                  w_err_in;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [31:0]           w_wword;
  logic [31:0]           w_ldata;

  assign w_accept = bus.req_valid && (r_state == IDLE);

  always_comb begin
    w_f3_ok = 1'b0;
    case (bus.req_funct3)
      3'b000, 3'b001, 3'b010: w_f3_ok = 1'b1;
      3'b100, 3'b101:         w_f3_ok = !bus.req_we;
      default:                w_f3_ok = 1'b0;
    endcase
  end

  assign w_misalign = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                      ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
  assign w_range    = |(bus.req_addr >> AW);
  assign w_err_in   = !w_f3_ok || w_misalign || w_range;

  // Request fields are frozen at acceptance; the core may change them freely afterwards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_we    <= 1'b0;
      r_f3    <= 3'b000;
      r_addr  <= '0;
      r_wdata <= '0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_we    <= bus.req_we;
      r_f3    <= bus.req_funct3;
      r_addr  <= bus.req_addr[AW-1:0];
      r_wdata <= bus.req_wdata;
      r_err   <= w_err_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_err_in)                                          w_next = RESP;
          else if (bus.req_we && (bus.req_funct3[1:0] == 2'b10)) w_next = WR;
          else                                                   w_next = RD;
        end
      end
      RD:      w_next = r_we ? WR : RESP;
      WR:      w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign w_idx = r_addr[AW-1:2];

  // No reset here: contents survive reset, and an async reset during WR has already
  // moved the state to IDLE before the write edge arrives.
  always_ff @(posedge clk) begin
    if (r_state == WR) r_mem[w_idx] <= w_wword;
    if (r_state == RD) r_rdata      <= r_mem[w_idx];
  end

  assign w_byte = r_rdata[{r_addr[1:0], 3'b000} +: 8];
  assign w_half = r_rdata[{r_addr[1], 4'b0000} +: 16];

  always_comb begin
    w_wword = r_rdata;
    case (r_f3[1:0])
      2'b00:   w_wword[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
      2'b01:   w_wword[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
      default: w_wword = r_wdata;
    endcase
  end

  always_comb begin
    w_ldata = r_rdata;
    case (r_f3)
      3'b000:  w_ldata = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_ldata = {{16{w_half[15]}}, w_half};
      3'b100:  w_ldata = {24'h000000, w_byte};
      3'b101:  w_ldata = {16'h0000, w_half};
      default: w_ldata = r_rdata;
    endcase
  end

  assign bus.req_ready = (r_state == IDLE);
  assign bus.busy      = (r_state != IDLE);
  assign bus.rsp_valid = (r_state == RESP);
  assign bus.rsp_err   = (r_state == RESP) && r_err;
  assign bus.rsp_rdata = ((r_state == RESP) && !r_err && !r_we) ? w_ldata : 32'h0;
  assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_lsu_rmw.sv
// Directed bench for lsu_rmw: loads, stores, read-modify-write, errors,
// reset during a write and a continuously-valid request stream.
module tb_lsu_rmw;
  logic       clk;
  logic       reset;
  logic [1:0] dbg_state;
  int         n_cmp;
  int         n_bad;

  lsu_rmw_if bus();

  lsu_rmw #(.DEPTH_LOG2(6)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver ----------------
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, output logic [31:0] rd, output logic er,
                       output int lat);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
    bus.req_addr  = addr; bus.req_wdata = wd;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b000;
    bus.req_addr  = 32'h0; bus.req_wdata = 32'h0;
    lat = -1; rd = 32'h0; er = 1'b0;
    for (int n = 1; n <= 8 && lat < 0; n++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        lat = n; rd = bus.rsp_rdata; er = bus.rsp_err;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    #3;
    n_cmp += 2;
    if (bus.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
    if (bus.busy !== 1'b0)      begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_cmp += 4;
    if (bus.req_ready !== 1'b1)  begin n_bad++; $display("FAIL reset_ready: got %b want 1", bus.req_ready); end
    if (bus.busy !== 1'b0)       begin n_bad++; $display("FAIL reset_busy_rel: got %b want 0", bus.busy); end
    if (bus.rsp_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0", bus.rsp_rdata); end
    if (bus.rsp_err !== 1'b0)    begin n_bad++; $display("FAIL reset_err: got %b want 0", bus.rsp_err); end
  endtask

  task automatic test_loads();
    logic [31:0] rd; logic er; int lat;
    logic [2:0]  f3  [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b000};
    logic [31:0] ad  [6] = '{32'h80, 32'h83, 32'h82, 32'h80, 32'h80, 32'h81};
    logic [31:0] exv [6] = '{32'hFFFFFFF1, 32'h00000080, 32'hFFFF8000,
                             32'h00007FF1, 32'h80007FF1, 32'h0000007F};
    issue(1'b1, 3'b010, 32'h80, 32'h80007FF1, rd, er, lat);
    n_cmp += 2;
    if (lat !== 2)     begin n_bad++; $display("FAIL preload_lat: got %0d want 2", lat); end
    if (rd !== 32'h0)  begin n_bad++; $display("FAIL preload_rdata: got %h want 0", rd); end
    for (int i = 0; i < 6; i++) begin
      issue(1'b0, f3[i], ad[i], 32'h0, rd, er, lat);
      n_cmp += 3;
      if (rd !== exv[i]) begin n_bad++; $display("FAIL load%0d data: got %h want %h", i, rd, exv[i]); end
      if (er !== 1'b0)   begin n_bad++; $display("FAIL load%0d err: got %b want 0", i, er); end
      if (lat !== 2)     begin n_bad++; $display("FAIL load%0d lat: got %0d want 2", i, lat); end
    end
  endtask

  task automatic test_store_load();
    logic [31:0] rd; logic er; int lat;
    issue(1'b1, 3'b010, 32'h64, 32'h00000019, rd, er, lat);
    n_cmp += 3;
    if (lat !== 2)    begin n_bad++; $display("FAIL sw64_lat: got %0d want 2", lat); end
    if (er !== 1'b0)  begin n_bad++; $display("FAIL sw64_err: got %b want 0", er); end
    if (rd !== 32'h0) begin n_bad++; $display("FAIL sw64_rdata: got %h want 0", rd); end
    issue(1'b0, 3'b010, 32'h64, 32'h0, rd, er, lat);
    n_cmp += 1;
    if (rd !== 32'h19) begin n_bad++; $display("FAIL lw64: got %h want 00000019", rd); end
  endtask

  task automatic test_subword_store();
    logic [31:0] rd; logic er; int lat;
    issue(1'b1, 3'b000, 32'h81, 32'h000000AB, rd, er, lat);
    n_cmp += 2;
    if (lat !== 3)    begin n_bad++; $display("FAIL sb81_lat: got %0d want 3", lat); end
    if (rd !== 32'h0) begin n_bad++; $display("FAIL sb81_rdata: got %h want 0", rd); end
    issue(1'b0, 3'b010, 32'h80, 32'h0, rd, er, lat);
    n_cmp += 1;
    if (rd !== 32'h8000ABF1) begin n_bad++; $display("FAIL after_sb: got %h want 8000abf1", rd); end
    issue(1'b1, 3'b001, 32'h82, 32'h00001234, rd, er, lat);
    n_cmp += 2;
    if (lat !== 3)   begin n_bad++; $display("FAIL sh82_lat: got %0d want 3", lat); end
    if (er !== 1'b0) begin n_bad++; $display("FAIL sh82_err: got %b want 0", er); end
    issue(1'b0, 3'b010, 32'h80, 32'h0, rd, er, lat);
    n_cmp += 1;
    if (rd !== 32'h1234ABF1) begin n_bad++; $display("FAIL after_sh: got %h want 1234abf1", rd); end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int lat;
    logic        we [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [2:0]  f3 [8] = '{3'b010, 3'b001, 3'b010, 3'b011, 3'b011, 3'b100, 3'b001, 3'b110};
    logic [31:0] ad [8] = '{32'h62, 32'h101, 32'h100, 32'h80, 32'h80, 32'h80, 32'h81, 32'h80};
    issue(1'b1, 3'b010, 32'h0, 32'h01020304, rd, er, lat);
    for (int i = 0; i < 8; i++) begin
      issue(we[i], f3[i], ad[i], 32'hFFFFFFFF, rd, er, lat);
      n_cmp += 3;
      if (er !== 1'b1)  begin n_bad++; $display("FAIL err%0d flag: got %b want 1", i, er); end
      if (rd !== 32'h0) begin n_bad++; $display("FAIL err%0d rdata: got %h want 0", i, rd); end
      if (lat !== 1)    begin n_bad++; $display("FAIL err%0d lat: got %0d want 1", i, lat); end
    end
    issue(1'b0, 3'b010, 32'h80, 32'h0, rd, er, lat);
    n_cmp += 1;
    if (rd !== 32'h1234ABF1) begin n_bad++; $display("FAIL err_mem80: got %h want 1234abf1", rd); end
    issue(1'b0, 3'b010, 32'h0, 32'h0, rd, er, lat);
    n_cmp += 1;
    if (rd !== 32'h01020304) begin n_bad++; $display("FAIL err_mem00: got %h want 01020304", rd); end
  endtask

  task automatic test_reset_during_wr();
    logic [31:0] rd; logic er; int lat;
    issue(1'b1, 3'b010, 32'h10, 32'h11223344, rd, er, lat);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'b010;
    bus.req_addr  = 32'h10; bus.req_wdata = 32'hDEADBEEF;
    @(posedge clk);
    #2;
    reset = 1'b1;
    bus.req_valid = 1'b0;
    #1;
    n_cmp += 2;
    if (bus.busy !== 1'b0)      begin n_bad++; $display("FAIL rstwr_busy: got %b want 0", bus.busy); end
    if (bus.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rstwr_valid: got %b want 0", bus.rsp_valid); end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp += 1;
      if (bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== 32'h0 || bus.rsp_err !== 1'b0 || bus.req_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL rstwr_idle%0d: got valid=%b rdata=%h err=%b ready=%b want 0/0/0/1",
                 c, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.req_ready);
      end
    end
    issue(1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat);
    n_cmp += 1;
    if (rd !== 32'h11223344) begin n_bad++; $display("FAIL rstwr_mem: got %h want 11223344", rd); end
  endtask

  typedef struct packed {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  lat;
    logic [31:0] exp;
    logic        err;
  } vec_t;

  task automatic test_back_to_back();
    logic [31:0] exp_q[$];
    logic        exp_err_q[$];
    int          exp_cyc_q[$];
    logic [31:0] rd; logic er; int lat;
    int          next_free;
    logic        exp_rdy;
    vec_t        tbl [15];
    tbl = '{
      '{1'b0, 3'b010, 32'h80, 32'h0,        4'd2, 32'h1234ABF1, 1'b0},
      '{1'b1, 3'b010, 32'h20, 32'h11111111, 4'd2, 32'h0,        1'b0},
      '{1'b1, 3'b000, 32'h20, 32'h00000022, 4'd3, 32'h0,        1'b0},
      '{1'b1, 3'b010, 32'h20, 32'hCAFEF00D, 4'd2, 32'h0,        1'b0},
      '{1'b1, 3'b010, 32'h20, 32'h33333333, 4'd2, 32'h0,        1'b0},
      '{1'b1, 3'b001, 32'h20, 32'h00004444, 4'd3, 32'h0,        1'b0},
      '{1'b0, 3'b000, 32'h21, 32'h0,        4'd2, 32'hFFFFFFF0, 1'b0},
      '{1'b1, 3'b010, 32'h20, 32'h0,        4'd2, 32'h0,        1'b0},
      '{1'b1, 3'b000, 32'h21, 32'h00000077, 4'd3, 32'h0,        1'b0},
      '{1'b0, 3'b010, 32'h62, 32'h0,        4'd1, 32'h0,        1'b1},
      '{1'b1, 3'b010, 32'h20, 32'h99999999, 4'd2, 32'h0,        1'b0},
      '{1'b1, 3'b001, 32'h22, 32'h00005555, 4'd3, 32'h0,        1'b0},
      '{1'b1, 3'b010, 32'h20, 32'hEEEEEEEE, 4'd2, 32'h0,        1'b0},
      '{1'b1, 3'b000, 32'h22, 32'h000000DD, 4'd3, 32'h0,        1'b0},
      '{1'b1, 3'b010, 32'h24, 32'hCCCCCCCC, 4'd2, 32'h0,        1'b0}
    };
    next_free = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      n_cmp += 1;
      if (exp_cyc_q.size() > 0 && exp_cyc_q[0] == k) begin
        if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== exp_q[0] || bus.rsp_err !== exp_err_q[0]) begin
          n_bad++;
          $display("FAIL b2b_rsp c%0d: got valid=%b rdata=%h err=%b want 1/%h/%b",
                   k, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, exp_q[0], exp_err_q[0]);
        end
        void'(exp_q.pop_front()); void'(exp_err_q.pop_front()); void'(exp_cyc_q.pop_front());
      end else if (bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== 32'h0 || bus.rsp_err !== 1'b0) begin
        n_bad++;
        $display("FAIL b2b_quiet c%0d: got valid=%b rdata=%h err=%b want 0/0/0",
                 k, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err);
      end
      exp_rdy = (k >= next_free);
      n_cmp += 1;
      if (bus.req_ready !== exp_rdy) begin
        n_bad++; $display("FAIL b2b_ready c%0d: got %b want %b", k, bus.req_ready, exp_rdy);
      end
      if (k < 15) begin
        bus.req_valid = 1'b1; bus.req_we = tbl[k].we; bus.req_funct3 = tbl[k].f3;
        bus.req_addr  = tbl[k].addr; bus.req_wdata = tbl[k].wd;
        if (exp_rdy) begin
          exp_q.push_back(tbl[k].exp);
          exp_err_q.push_back(tbl[k].err);
          exp_cyc_q.push_back(k + int'(tbl[k].lat));
          next_free = k + int'(tbl[k].lat) + 1;
        end
      end else begin
        bus.req_valid = 1'b0;
      end
    end
    n_cmp += 1;
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL b2b_drain: got %0d outstanding want 0", exp_q.size()); end
    issue(1'b0, 3'b010, 32'h20, 32'h0, rd, er, lat);
    n_cmp += 1;
    if (rd !== 32'h5555F00D) begin n_bad++; $display("FAIL b2b_mem20: got %h want 5555f00d", rd); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_cmp = 0; n_bad = 0;
    reset = 1'b1;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b000;
    bus.req_addr  = 32'h0; bus.req_wdata = 32'h0;
    test_reset();
    test_loads();
    test_store_load();
    test_subword_store();
    test_errors();
    test_reset_during_wr();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/lsu_rmw.md
LSU_RMW -- requirements
Module: lsu_rmw

Interface
REQ-001 SHALL have parameter: DEPTH_LOG2, 6, log2 of internal data-memory depth in 32-bit words.
REQ-002 SHALL have port: clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: req_valid  input  1  core presents a load/store request.
REQ-005 SHALL have port: req_ready  output  1  block can accept a request this cycle.
REQ-006 SHALL have port: req_we  input  1  1 = store, 0 = load.
REQ-007 SHALL have port: req_funct3  input  3  RV32I load/store funct3.
REQ-008 SHALL have port: req_addr  input  32  byte address.
REQ-009 SHALL have port: req_wdata  input  32  store data, right-aligned.
REQ-010 SHALL have port: rsp_valid  output  1  one-cycle completion pulse.
REQ-011 SHALL have port: rsp_rdata  output  32  extended load data.
REQ-012 SHALL have port: rsp_err  output  1  request rejected, qualified by rsp_valid.
REQ-013 SHALL have port: busy  output  1  stall to core; high in every state except IDLE.

Function
REQ-014 SHALL contain 2**DEPTH_LOG2 x 32 word memory with synchronous write and a registered read; array hierarchically accessible for $readmemh preload.
REQ-015 SHALL implement FSM states IDLE, RD, WR, RESP; req_ready = (state == IDLE).
REQ-016 SHALL accept a request only on a rising edge with req_valid & req_ready; all req_* fields captured then, later changes ignored until next IDLE.
REQ-017 Legal loads SHALL be funct3 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; legal stores 000 sb, 001 sh, 010 sw; any other funct3 is an error.
REQ-018 Error SHALL also flag: halfword access with addr[0]=1; word access with addr[1:0]!=0; addr[31:DEPTH_LOG2+2] != 0.
REQ-019 On accept: error -> RESP; load or sb/sh -> RD; sw -> WR.
REQ-020 RD SHALL present the word index addr[DEPTH_LOG2+1:2] and register the read word at end of cycle; RD -> RESP for loads, RD -> WR for sb/sh.
REQ-021 WR SHALL write at the rising edge ending WR: sw writes req_wdata; sb replaces byte lane addr[1:0] with wdata[7:0]; sh replaces halfword lane addr[1] with wdata[15:0]; other lanes keep the RD value. WR -> RESP.
REQ-022 RESP SHALL assert rsp_valid for exactly one cycle, then -> IDLE; no response back-pressure.
REQ-023 In RESP, loads SHALL output the selected byte/halfword/word, sign-extended for lb/lh, zero-extended for lbu/lhu; rsp_err=0.
REQ-024 In RESP for stores, rsp_rdata=0 and rsp_err=0; for errors rsp_rdata=0, rsp_err=1, and memory unmodified.
REQ-025 rsp_rdata and rsp_err SHALL be 0 whenever rsp_valid=0.
REQ-026 Latency from accepting cycle 0: error rsp in cycle 1; lw/lh/lb/sw in cycle 2; sb/sh in cycle 3; next accept earliest the cycle after RESP.
REQ-027 A load following a store SHALL return the stored data (write completes before RESP).

Reset
REQ-028 On reset assertion, state SHALL go to IDLE immediately; rsp_valid, rsp_rdata, rsp_err, busy = 0; req_ready = 1 once released.
REQ-029 Memory contents SHALL NOT be cleared by reset; reset asserted during WR SHALL suppress that write; any in-flight request is dropped without a response.

Verification
REQ-030 Preload word at 0x80 = 0x80007FF1: lb 0x80 -> 0xFFFFFFF1, lbu 0x83 -> 0x00000080, lh 0x82 -> 0xFFFF8000, lhu 0x80 -> 0x00007FF1, each with rsp_valid in cycle 2.
REQ-031 sw 0x64 data 0x00000019 -> rsp_valid in cycle 2, rsp_err=0; following lw 0x64 -> 0x00000019.
REQ-032 sb 0x81 wdata 0x000000AB onto 0x80007FF1 -> rsp in cycle 3; lw 0x80 -> 0x8000ABF1; sh 0x82 wdata 0x1234 -> word 0x1234ABF1.
REQ-033 lw 0x62, sh 0x101, sw 0x100 (DEPTH_LOG2=6), funct3 011 -> rsp_err=1 in cycle 1, rsp_rdata=0, memory unchanged.
REQ-034 sw 0x10 data 0xDEADBEEF with reset pulsed during WR -> word 0x10 keeps preload value, no rsp_valid, outputs 0, req_ready=1 after release.
REQ-035 req_valid held high with fields changing every cycle -> requests accepted only in IDLE cycles; each response matches the fields sampled at its acceptance edge.
